acc_exec_unit: RTL and testbench
================================

Name: acc_exec_unit

Overview:
- Execute stage directly downstream of the instruction decoder.
- Consumes one decoded 6-bit instruction (3-bit opcode, 3-bit argument) per handshake.
- Owns the accumulator, a small register file and the Z/C flags.
- Most ops complete in one cycle. MUL is an iterative shift-add that stalls the upstream stage through op_ready.

Parameters:
DW, 8, data width of accumulator and registers (must be >= 3)
NREG, 4, number of general registers; index = arg[log2(NREG)-1:0]

Ports:
clk  input  1  system clock, all state on rising edge
nReset  input  1  asynchronous active-low reset
op_valid  input  1  decoder presents a valid instruction
op_ready  output  1  unit can accept an instruction this cycle
opcode  input  3  decoded operation
arg  input  3  immediate / register index / shift amount
acc  output  DW  accumulator value
flag_z  output  1  zero flag
flag_c  output  1  carry/borrow flag
done  output  1  one-cycle pulse when an instruction retires

Behaviour:
- Reset (nReset low, asynchronous):
  - acc=0, all registers=0, flag_z=0, flag_c=0, done=0.
  - FSM=IDLE, op_ready=1.
  - Asserting reset mid-MUL aborts it: no acc/flag write, state returns to IDLE immediately.
- Accept: instruction taken on a rising edge with op_valid && op_ready. opcode/arg are sampled only at accept.
- op_ready is 1 in IDLE and 0 in MUL_RUN. It depends only on state, never combinationally on op_valid.
- Opcodes (R = reg[arg index], results truncated to DW):
  - 000 NOP: no state change except done.
  - 001 LDI: acc <= zero-extended arg. C unchanged.
  - 010 ADD: {C,acc} <= acc + R.
  - 011 SUB: acc <= acc - R. C <= 1 if R > acc (borrow), else 0.
  - 100 ST: R <= acc. acc and flags unchanged.
  - 101 AND: acc <= acc & R. C <= 0.
  - 110 SHL: acc <= acc << arg (0..7).
    - C <= last bit shifted out.
    - arg=0: acc unchanged, C <= 0.
    - arg >= DW: acc <= 0, C <= 0 unless arg == DW, in which case C <= acc[0].
  - 111 MUL: acc <= low DW bits of acc * R. C <= 1 if the full product overflows DW bits.
- Z rule: Z <= (new acc == 0) on every op that writes acc (LDI, ADD, SUB, AND, SHL, MUL). Z is unchanged on NOP and ST.
- Single-cycle ops: result visible the cycle after the accept edge. done=1 for that one cycle.
- MUL FSM:
  - IDLE --accept MUL--> MUL_RUN.
    - Latch multiplicand = acc, multiplier = R.
    - Clear product accumulator (2*DW bits).
    - Iteration counter = 0.
  - MUL_RUN, each cycle:
    - If multiplier LSB is set, add shifted multiplicand.
    - Shift multiplicand left, shift multiplier right, counter++.
  - After exactly DW iterations: write acc/Z/C, pulse done, return to IDLE.
  - Latency accept->done = DW+1 cycles (9 for DW=8).
  - op_ready is 0 for DW cycles and returns to 1 in the same cycle done pulses.
  - Instructions are not accepted during MUL_RUN. op_valid held by upstream is simply not consumed.
- Back-to-back: in IDLE an instruction may be accepted every cycle. A new instruction sees the result of the previous one, with no hazard.
- ST then ADD of the same register in consecutive accepts: ADD uses the freshly stored value.
- Register index ignores arg bits above log2(NREG).
- No X on outputs after reset. Register file is not externally visible except through acc.

Test Plan:
- Reset then idle → acc=0x00, flag_z=0, flag_c=0, op_ready=1, done=0. Release nReset off-edge at 6 ns → no glitch on outputs.
- LDI 5; ST r1; LDI 3; ADD r1 → acc=0x08, Z=0, C=0. done pulses 4 times on consecutive cycles.
- LDI 0; SUB r1 (r1=5) → acc=0xFB, C=1, Z=0. Then LDI 0; AND r1 → acc=0x00, Z=1, C=0.
- LDI 7; SHL 5 → acc=0xE0, C=0. SHL 1 → acc=0xC0, C=1. SHL 0 → acc unchanged, C=0.
- acc=0xE0, r2=0x06, MUL r2 with op_valid held high → op_ready low 8 cycles, done at 9th cycle, acc=0x40, C=1, Z=0. Next instruction accepted in the done cycle.
- Start MUL, assert nReset low after 3 cycles → acc=0, registers 0, op_ready=1 immediately. After release, LDI 2 executes normally → acc=0x02.

Source files
------------

// File: rtl/acc_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : acc_exec_unit_if
// Description : Decoder-to-execute handshake bundle. The decoder side
//               presents a decoded instruction; the execute side returns
//               ready, the accumulator, the flags and a retire pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface acc_exec_unit_if #(
  parameter int DW = 8
);
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    opcode;
  logic [2:0]    arg;
  logic [DW-1:0] acc;
  logic          flag_z;
  logic          flag_c;
  logic          done;

  // Decoder side
  modport master (
    output op_valid, opcode, arg,
    input  op_ready, acc, flag_z, flag_c, done
  );

  // Execute side
  modport slave (
    input  op_valid, opcode, arg,
    output op_ready, acc, flag_z, flag_c, done
  );
endinterface
`default_nettype wire

// File: rtl/acc_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : acc_exec_unit
// Description : Accumulator execute stage. Holds the accumulator, a small
//               register file and Z/C flags. Single-cycle ALU ops plus an
//               iterative shift-add multiply that stalls upstream via
//               op_ready while it runs.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_exec_unit #(
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  logic           clk,
  input  logic           nReset,
  acc_exec_unit_if.slave bus
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int CW = $clog2(DW + 1);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_ST  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_MUL_RUN = 1'b1;

  // FSM
  logic [0:0]      state_q, state_d;
  logic            ready;
  logic            accept;
  logic            mul_last;

  // Architectural state
  logic [DW-1:0]   acc_q, acc_d;
  logic            z_q, z_d;
  logic            c_q, c_d;
  logic            done_q, done_d;
  logic [DW-1:0]   regs_q [NREG];
  logic            st_en;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   reg_r;

  // Multiplier working state
  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [2*DW-1:0] prod_q, prod_d;
  logic [2*DW-1:0] prod_step;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // ALU intermediates (one extra bit carries C out)
  logic [DW:0]     sum;
  logic [DW:0]     diff;
  logic [DW:0]     shl_ext;
  logic [DW-1:0]   and_res;

  // Only the low index bits of arg select a register
  assign idx      = bus.arg[IW-1:0];
  assign reg_r    = regs_q[idx];
  assign accept   = bus.op_valid && ready;
  assign mul_last = (cnt_q == CW'(DW - 1));

  // State register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter MUL_RUN on an accepted MUL, leave after DW iterations
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept && (bus.opcode == OP_MUL)) state_d = S_MUL_RUN;
      S_MUL_RUN: if (mul_last) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ready is purely a function of state
  always_comb begin
    ready = (state_q == S_IDLE);
  end

  // Datapath next-state: single-cycle ALU ops, multiply setup and iteration
  always_comb begin
    acc_d    = acc_q;
    z_d      = z_q;
    c_d      = c_q;
    done_d   = 1'b0;
    st_en    = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;

    sum       = {1'b0, acc_q} + {1'b0, reg_r};
    diff      = {1'b0, acc_q} - {1'b0, reg_r};
    // Bit DW of the widened shift is exactly the last bit shifted out,
    // and zero when arg is 0 or exceeds DW
    shl_ext   = {1'b0, acc_q} << bus.arg;
    and_res   = acc_q & reg_r;
    prod_step = prod_q + (mplier_q[0] ? mcand_q : {(2*DW){1'b0}});

    if (accept) begin
      case (bus.opcode)
        OP_NOP: begin
          done_d = 1'b1;
        end
        OP_LDI: begin
          acc_d  = DW'(bus.arg);
          z_d    = (bus.arg == 3'd0);
          done_d = 1'b1;
        end
        OP_ADD: begin
          acc_d  = sum[DW-1:0];
          c_d    = sum[DW];
          z_d    = (sum[DW-1:0] == '0);
          done_d = 1'b1;
        end
        OP_SUB: begin
          acc_d  = diff[DW-1:0];
          c_d    = diff[DW];
          z_d    = (diff[DW-1:0] == '0);
          done_d = 1'b1;
        end
        OP_ST: begin
          st_en  = 1'b1;
          done_d = 1'b1;
        end
        OP_AND: begin
          acc_d  = and_res;
          c_d    = 1'b0;
          z_d    = (and_res == '0);
          done_d = 1'b1;
        end
        OP_SHL: begin
          acc_d  = shl_ext[DW-1:0];
          c_d    = shl_ext[DW];
          z_d    = (shl_ext[DW-1:0] == '0);
          done_d = 1'b1;
        end
        OP_MUL: begin
          mcand_d  = {{DW{1'b0}}, acc_q};
          mplier_d = reg_r;
          prod_d   = '0;
          cnt_d    = '0;
        end
        default: begin
          done_d = 1'b1;
        end
      endcase
    end else if (state_q == S_MUL_RUN) begin
      prod_d   = prod_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (mul_last) begin
        acc_d  = prod_step[DW-1:0];
        c_d    = |prod_step[2*DW-1:DW];
        z_d    = (prod_step[DW-1:0] == '0);
        done_d = 1'b1;
      end
    end
  end

  // Datapath registers; reset mid-multiply discards all work in progress
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      acc_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      z_q      <= z_d;
      c_q      <= c_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  // Register file: written only by ST, read combinationally by the ALU
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (st_en) begin
      regs_q[idx] <= acc_q;
    end
  end

  assign bus.op_ready = ready;
  assign bus.acc      = acc_q;
  assign bus.flag_z   = z_q;
  assign bus.flag_c   = c_q;
  assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_exec_unit
// Description : Directed self-checking bench for acc_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_exec_unit;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_ST  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic clk;
  logic nReset;
  int   n_pass;
  int   n_total;

  acc_exec_unit_if #(.DW(8)) bus ();

  acc_exec_unit #(.DW(8), .NREG(4)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one instruction for exactly one edge; returns 1 ns after it
  task automatic exec(input logic [2:0] op, input logic [2:0] a);
    bus.op_valid = 1'b1;
    bus.opcode   = op;
    bus.arg      = a;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic test_reset;
    nReset       = 1'b0;
    bus.op_valid = 1'b0;
    bus.opcode   = OP_NOP;
    bus.arg      = 3'd0;
    #3;
    n_total++;
    if (bus.acc !== 8'h00 || bus.flag_z !== 1'b0 || bus.flag_c !== 1'b0 ||
        bus.op_ready !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL reset_hold: acc=%h z=%b c=%b rdy=%b done=%b want 00 0 0 1 0",
               bus.acc, bus.flag_z, bus.flag_c, bus.op_ready, bus.done);
    else n_pass++;
    #3;
    nReset = 1'b1;   // released off-edge at 6 ns
    #1;
    n_total++;
    if (bus.acc !== 8'h00 || bus.done !== 1'b0 || bus.op_ready !== 1'b1)
      $display("FAIL reset_release: acc=%h done=%b rdy=%b want 00 0 1",
               bus.acc, bus.done, bus.op_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.acc !== 8'h00 || bus.flag_z !== 1'b0 || bus.flag_c !== 1'b0 ||
        bus.op_ready !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL reset_idle: acc=%h z=%b c=%b rdy=%b done=%b want 00 0 0 1 0",
               bus.acc, bus.flag_z, bus.flag_c, bus.op_ready, bus.done);
    else n_pass++;
  endtask

  task automatic test_add;
    int dones;
    dones = 0;
    exec(OP_LDI, 3'd5); if (bus.done === 1'b1) dones++;
    exec(OP_ST,  3'd1); if (bus.done === 1'b1) dones++;
    n_total++;
    if (bus.acc !== 8'h05) $display("FAIL st_keeps_acc: acc=%h want 05", bus.acc);
    else n_pass++;
    exec(OP_LDI, 3'd3); if (bus.done === 1'b1) dones++;
    exec(OP_ADD, 3'd1); if (bus.done === 1'b1) dones++;
    n_total++;
    if (bus.acc !== 8'h08 || bus.flag_z !== 1'b0 || bus.flag_c !== 1'b0)
      $display("FAIL add: acc=%h z=%b c=%b want 08 0 0", bus.acc, bus.flag_z, bus.flag_c);
    else n_pass++;
    n_total++;
    if (dones !== 4) $display("FAIL add_done_pulses: got %0d want 4", dones);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.done !== 1'b0 || bus.acc !== 8'h08)
      $display("FAIL idle_after_add: done=%b acc=%h want 0 08", bus.done, bus.acc);
    else n_pass++;
  endtask

  task automatic test_sub_and;
    exec(OP_LDI, 3'd0);
    exec(OP_SUB, 3'd1);
    n_total++;
    if (bus.acc !== 8'hFB || bus.flag_c !== 1'b1 || bus.flag_z !== 1'b0)
      $display("FAIL sub_borrow: acc=%h c=%b z=%b want FB 1 0", bus.acc, bus.flag_c, bus.flag_z);
    else n_pass++;
    exec(OP_LDI, 3'd0);
    exec(OP_AND, 3'd1);
    n_total++;
    if (bus.acc !== 8'h00 || bus.flag_z !== 1'b1 || bus.flag_c !== 1'b0)
      $display("FAIL and_zero: acc=%h z=%b c=%b want 00 1 0", bus.acc, bus.flag_z, bus.flag_c);
    else n_pass++;
    // NOP leaves acc and flags alone but still retires
    exec(OP_NOP, 3'd7);
    n_total++;
    if (bus.acc !== 8'h00 || bus.flag_z !== 1'b1 || bus.flag_c !== 1'b0 || bus.done !== 1'b1)
      $display("FAIL nop: acc=%h z=%b c=%b done=%b want 00 1 0 1",
               bus.acc, bus.flag_z, bus.flag_c, bus.done);
    else n_pass++;
  endtask

  task automatic test_shl;
    exec(OP_LDI, 3'd7);
    exec(OP_SHL, 3'd5);
    n_total++;
    if (bus.acc !== 8'hE0 || bus.flag_c !== 1'b0 || bus.flag_z !== 1'b0)
      $display("FAIL shl5: acc=%h c=%b z=%b want E0 0 0", bus.acc, bus.flag_c, bus.flag_z);
    else n_pass++;
    exec(OP_SHL, 3'd1);
    n_total++;
    if (bus.acc !== 8'hC0 || bus.flag_c !== 1'b1)
      $display("FAIL shl1: acc=%h c=%b want C0 1", bus.acc, bus.flag_c);
    else n_pass++;
    exec(OP_SHL, 3'd0);
    n_total++;
    if (bus.acc !== 8'hC0 || bus.flag_c !== 1'b0 || bus.flag_z !== 1'b0)
      $display("FAIL shl0: acc=%h c=%b z=%b want C0 0 0", bus.acc, bus.flag_c, bus.flag_z);
    else n_pass++;
  endtask

  task automatic test_mul;
    int lo;
    exec(OP_LDI, 3'd6);
    exec(OP_ST,  3'd2);
    exec(OP_LDI, 3'd7);
    exec(OP_SHL, 3'd5);   // acc = E0
    // MUL r2, then keep op_valid high with the next instruction waiting
    bus.op_valid = 1'b1;
    bus.opcode   = OP_MUL;
    bus.arg      = 3'd2;
    @(posedge clk);
    #1;
    bus.opcode = OP_LDI;
    bus.arg    = 3'd4;
    lo = 0;
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) begin
      if (bus.op_ready === 1'b0) lo++;
      @(posedge clk);
      #1;
    end
    n_total++;
    if (bus.done !== 1'b1) $display("FAIL mul_timeout: done=%b want 1", bus.done);
    else n_pass++;
    n_total++;
    if (lo !== 8) $display("FAIL mul_stall_cycles: got %0d want 8", lo);
    else n_pass++;
    n_total++;
    if (bus.acc !== 8'h40 || bus.flag_c !== 1'b1 || bus.flag_z !== 1'b0 || bus.op_ready !== 1'b1)
      $display("FAIL mul_result: acc=%h c=%b z=%b rdy=%b want 40 1 0 1",
               bus.acc, bus.flag_c, bus.flag_z, bus.op_ready);
    else n_pass++;
    // Held LDI 4 is taken on the edge that ends the done cycle
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    n_total++;
    if (bus.acc !== 8'h04 || bus.done !== 1'b1 || bus.flag_z !== 1'b0)
      $display("FAIL after_mul_accept: acc=%h done=%b z=%b want 04 1 0",
               bus.acc, bus.done, bus.flag_z);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul;
    bus.op_valid = 1'b1;
    bus.opcode   = OP_MUL;
    bus.arg      = 3'd2;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    nReset = 1'b0;
    #1;
    n_total++;
    if (bus.acc !== 8'h00 || bus.op_ready !== 1'b1 || bus.done !== 1'b0 ||
        bus.flag_c !== 1'b0 || bus.flag_z !== 1'b0)
      $display("FAIL mul_abort: acc=%h rdy=%b done=%b c=%b z=%b want 00 1 0 0 0",
               bus.acc, bus.op_ready, bus.done, bus.flag_c, bus.flag_z);
    else n_pass++;
    #2;
    nReset = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.done !== 1'b0 || bus.acc !== 8'h00)
      $display("FAIL abort_no_retire: done=%b acc=%h want 0 00", bus.done, bus.acc);
    else n_pass++;
    exec(OP_LDI, 3'd2);
    n_total++;
    if (bus.acc !== 8'h02 || bus.done !== 1'b1)
      $display("FAIL ldi_after_reset: acc=%h done=%b want 02 1", bus.acc, bus.done);
    else n_pass++;
    // r2 was cleared by reset, so ADD r2 leaves acc at 2
    exec(OP_ADD, 3'd2);
    n_total++;
    if (bus.acc !== 8'h02 || bus.flag_c !== 1'b0)
      $display("FAIL regs_cleared: acc=%h c=%b want 02 0", bus.acc, bus.flag_c);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    exec(OP_ST,  3'd1);   // r1 = 02
    exec(OP_ADD, 3'd1);   // uses freshly stored r1
    n_total++;
    if (bus.acc !== 8'h04) $display("FAIL st_add_forward: acc=%h want 04", bus.acc);
    else n_pass++;
    exec(OP_ADD, 3'd5);   // arg 5 selects r1
    n_total++;
    if (bus.acc !== 8'h06) $display("FAIL index_alias: acc=%h want 06", bus.acc);
    else n_pass++;
    exec(OP_LDI, 3'd7);
    exec(OP_SHL, 3'd5);   // E0
    exec(OP_ST,  3'd3);
    exec(OP_ADD, 3'd3);   // E0 + E0 = 1C0
    n_total++;
    if (bus.acc !== 8'hC0 || bus.flag_c !== 1'b1 || bus.flag_z !== 1'b0)
      $display("FAIL add_carry: acc=%h c=%b z=%b want C0 1 0", bus.acc, bus.flag_c, bus.flag_z);
    else n_pass++;
    exec(OP_SUB, 3'd3);   // C0 - E0 = E0 with borrow
    n_total++;
    if (bus.acc !== 8'hE0 || bus.flag_c !== 1'b1)
      $display("FAIL sub_borrow2: acc=%h c=%b want E0 1", bus.acc, bus.flag_c);
    else n_pass++;
    exec(OP_SUB, 3'd3);   // E0 - E0 = 0, no borrow
    n_total++;
    if (bus.acc !== 8'h00 || bus.flag_z !== 1'b1 || bus.flag_c !== 1'b0)
      $display("FAIL sub_zero: acc=%h z=%b c=%b want 00 1 0", bus.acc, bus.flag_z, bus.flag_c);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_add();
    test_sub_and();
    test_shl();
    test_mul();
    test_reset_mid_mul();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
